// File: rtl/frontier_packer.sv
// frontier_packer: packs the 4-lane sparse filter output into dense 4-word
// lines. Order is preserved (lower lane first, older beat first). A last beat
// flushes the partial tail, and the line that empties the accumulator is
// tagged with out_last.
module frontier_packer #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           last_input_in,
    input  logic [3:0]                     word_in_valid,
    input  logic [3:0][DATA_WIDTH-1:0]     word_in,
    output logic                           in_ready,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [3:0][DATA_WIDTH-1:0]     out_word,
    output logic [3:0]                     out_word_valid,
    output logic                           out_last,
    output logic                           overflow_err,
    output logic [CNT_WIDTH-1:0]           line_count
);
    localparam int LANES = 4;
    localparam int DEPTH = 8;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

    logic [0:0]                       state, state_nxt;
    logic [3:0]                       cnt, cnt_nxt;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] acc, acc_nxt, merged;
    logic [3:0]                       t, take;
    logic                             beat, accept, slot_free, load, last_nxt;
    logic [LANES-1:0]                 mask_nxt;
    logic [LANES-1:0][DATA_WIDTH-1:0] word_nxt;

    assign beat      = (|word_in_valid) | last_input_in;
    assign in_ready  = (state == ST_RUN) && (cnt <= 4'd3);
    assign accept    = beat && in_ready;
    assign slot_free = !out_valid || out_ready;

    // Scatter accepted words in lane order directly behind the held words
    always_comb begin
        merged = acc;
        t      = cnt;
        for (int l = 0; l < LANES; l++) begin
            if (accept && word_in_valid[l]) begin
                merged[t[2:0]] = word_in[l];
                t              = t + 4'd1;
            end
        end
    end

    // Decide whether the line slot reloads, how many words it takes and the next state
    always_comb begin
        load      = 1'b0;
        take      = 4'd0;
        mask_nxt  = '0;
        last_nxt  = 1'b0;
        cnt_nxt   = t;
        state_nxt = state;
        if (state == ST_RUN) begin
            if (slot_free && t >= 4'd4) begin
                load     = 1'b1;
                take     = 4'd4;
                mask_nxt = '1;
                cnt_nxt  = t - 4'd4;
                // A last beat whose full line empties the accumulator ends the stream here
                if (accept && last_input_in) begin
                    if (t == 4'd4) last_nxt  = 1'b1;
                    else           state_nxt = ST_FLUSH;
                end
            end else if (accept && last_input_in) begin
                state_nxt = ST_FLUSH;
            end
        end else if (slot_free) begin
            load = 1'b1;
            if (cnt > 4'd4) begin
                take     = 4'd4;
                mask_nxt = '1;
                cnt_nxt  = cnt - 4'd4;
            end else begin
                // Tail line (possibly empty) closes the stream
                take      = cnt;
                last_nxt  = 1'b1;
                cnt_nxt   = 4'd0;
                state_nxt = ST_RUN;
                for (int l = 0; l < LANES; l++) mask_nxt[l] = (l < int'(cnt));
            end
        end
    end

    // Slot contents from the oldest words, accumulator shifted down by what left
    always_comb begin
        logic [3:0] idx;
        word_nxt = '0;
        acc_nxt  = '0;
        for (int l = 0; l < LANES; l++) begin
            if (l < int'(take)) word_nxt[l] = merged[l];
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = 4'(i) + take;
            if (i + int'(take) < DEPTH) acc_nxt[i] = merged[idx[2:0]];
        end
    end

    // State, accumulator, output slot, sticky error and accepted-line counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_RUN;
            cnt            <= 4'd0;
            acc            <= '0;
            out_valid      <= 1'b0;
            out_word       <= '0;
            out_word_valid <= '0;
            out_last       <= 1'b0;
            overflow_err   <= 1'b0;
            line_count     <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            acc   <= acc_nxt;
            if (beat && !in_ready) overflow_err <= 1'b1;
            if (out_valid && out_ready) line_count <= line_count + CNT_WIDTH'(1);
            if (load) begin
                out_valid      <= 1'b1;
                out_word       <= word_nxt;
                out_word_valid <= mask_nxt;
                out_last       <= last_nxt;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule
